frame_arbiter: RTL and testbench

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter_pkg.sv | 20 ++
 rtl/frame_rr_pick.sv | 29 ++
 rtl/frame_arbiter.sv | 134 +++++++++++++
 tb/tb_frame_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_arbiter_pkg.sv
// Shared types and sizing helpers for the frame arbiter.
package frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module frame_rr_pick
  import frame_arbiter_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IW       = idx_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [IW-1:0]       rr_ptr_i,
  output logic [IW-1:0]       index_o,
  output logic                found_o
);

  // Scan upward from the pointer; the first hit wins.
  always_comb begin
    int c;
    c       = 0;
    index_o = '0;
    found_o = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      c = (int'(rr_ptr_i) + k) % NUM_REQS;
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        index_o = IW'(c);
      end
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Frame-granular round-robin arbiter with inter-frame gap and stall-timeout abort.
module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int NUM_REQS      = 4,
  parameter int DATAW         = 8,
  parameter int IFG_CYCLES    = 12,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           valid_in,
  input  logic [NUM_REQS*DATAW-1:0]     data_in,
  input  logic [NUM_REQS-1:0]           last_in,
  output logic [NUM_REQS-1:0]           ready_in,
  output logic                          valid_out,
  output logic [DATAW-1:0]              data_out,
  output logic                          last_out,
  input  logic                          ready_out,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQS)-1:0]   grant_index,
  output logic                          frame_abort
);

  localparam int IW         = $clog2(NUM_REQS);
  localparam int GW         = cnt_w(IFG_CYCLES);
  localparam int SW         = cnt_w(STALL_TIMEOUT);
  localparam int GAP_LOAD   = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam int STALL_LAST = (STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0;
  localparam bit GAP_EN     = (IFG_CYCLES > 0);
  localparam bit STALL_EN   = (STALL_TIMEOUT > 0);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [IW-1:0]   grant_nxt;
  logic            sel_valid, sel_last;
  logic            end_frame;
  logic [DATAW-1:0] din [NUM_REQS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_din
    assign din[i] = data_in[i*DATAW +: DATAW];
  end

  frame_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .IW       (IW)
  ) u_pick (
    .req_i    (valid_in),
    .rr_ptr_i (rr_q),
    .index_o  (pick_idx),
    .found_o  (pick_found)
  );

  assign sel_valid   = valid_in[grant_q];
  assign sel_last    = last_in[grant_q];
  assign data_out    = din[grant_q];
  assign grant_valid = (state_q == XFER);
  assign grant_index = grant_q;
  assign grant_nxt   = (grant_q == IW'(NUM_REQS - 1)) ? '0 : grant_q + 1'b1;

  // Next state, output steering, and frame-end / stall bookkeeping.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    gap_d       = gap_q;
    stall_d     = stall_q;
    valid_out   = 1'b0;
    last_out    = 1'b0;
    ready_in    = '0;
    frame_abort = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        valid_out         = sel_valid;
        last_out          = sel_last;
        ready_in[grant_q] = ready_out;
        if (sel_valid) begin
          stall_d = '0;
          if (ready_out && sel_last) end_frame = 1'b1;
        end else if (ready_out) begin
          // Only source-side stalls count; a backpressured output holds the count.
          if (STALL_EN && stall_q == SW'(STALL_LAST)) begin
            frame_abort = 1'b1;
            end_frame   = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        if (end_frame) begin
          rr_d    = grant_nxt;
          stall_d = '0;
          gap_d   = GW'(GAP_LOAD);
          state_d = GAP_EN ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// Scoreboard bench for frame_arbiter: behavioural sources, expected beats queued in grant order.
module tb_frame_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    valid_in, last_in, ready_in;
  logic [N*DW-1:0] data_in;
  logic            valid_out, last_out, ready_out, grant_valid, frame_abort;
  logic [DW-1:0]   data_out;
  logic [1:0]      grant_index;

  logic [N-1:0]    ready_in0;
  logic            valid_out0, last_out0, grant_valid0, frame_abort0;
  logic [DW-1:0]   data_out0;
  logic [1:0]      grant_index0;

  frame_arbiter #(.NUM_REQS(N), .DATAW(DW), .IFG_CYCLES(12), .STALL_TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
    .ready_out(ready_out), .grant_valid(grant_valid), .grant_index(grant_index),
    .frame_abort(frame_abort)
  );

  frame_arbiter #(.NUM_REQS(N), .DATAW(DW), .IFG_CYCLES(0), .STALL_TIMEOUT(256)) u_dut0 (
    .clk(clk), .reset(reset), .valid_in(4'b0001), .data_in(32'h0000_00A5), .last_in(4'b0001),
    .ready_in(ready_in0), .valid_out(valid_out0), .data_out(data_out0), .last_out(last_out0),
    .ready_out(1'b1), .grant_valid(grant_valid0), .grant_index(grant_index0),
    .frame_abort(frame_abort0)
  );

  always #5 clk = ~clk;

  int    n_tests = 0, n_fail = 0, cyc = 0;
  beat_t sb[$];
  int    beat[N], fcnt[N], fleft[N], len[N], pause_at[N];
  bit    en[N], resumed[N];
  bit    rst_req, rdy_pat, chk_gap, pend;
  int    last_cyc, last_acc_cyc, n_abort;
  logic [N-1:0] adv;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int i, input int f, input int b);
    return DW'(((i & 3) << 6) | ((f & 3) << 4) | (b & 15));
  endfunction

  task automatic src_init(input int i, input int nf, input int l, input int f0);
    en[i] = 1'b1; fleft[i] = nf; len[i] = l; beat[i] = 0; fcnt[i] = f0;
    pause_at[i] = -1; resumed[i] = 1'b0;
  endtask

  task automatic push_frame(input int i, input int f, input int b0, input int l);
    beat_t e;
    for (int b = b0; b < l; b++) begin
      e.idx  = 2'(i);
      e.data = mk_data(i, f, b);
      e.last = (b == l - 1);
      sb.push_back(e);
    end
  endtask

  // Drive inputs on the falling edge, then check outputs once they settle.
  task automatic drive_sample();
    logic [N-1:0] exp_rdy;
    beat_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      valid_in[i] = en[i] && (fleft[i] > 0) && !(beat[i] == pause_at[i] && !resumed[i]);
      data_in[i*DW +: DW] = mk_data(i, fcnt[i], beat[i]);
      last_in[i] = (beat[i] == len[i] - 1);
    end
    ready_out = rdy_pat ? cyc[0] : 1'b1;
    reset     = rst_req;
    #1;
    if (!rst_req) begin
      exp_rdy = grant_valid ? (N'(ready_out) << grant_index) : '0;
      chk("ready_in", 32'(ready_in), 32'(exp_rdy));
      chk("valid_out", 32'(valid_out), 32'(grant_valid && valid_in[grant_index]));
      if (valid_out && pend && chk_gap) begin
        chk("ifg_gap", cyc - last_cyc, 14);
        pend = 1'b0;
      end
      if (frame_abort) begin
        n_abort++;
        chk("abort_dly", cyc - last_acc_cyc, 8);
      end
      if (valid_out && ready_out) begin
        last_acc_cyc = cyc;
        if (last_out) begin last_cyc = cyc; pend = 1'b1; end
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("beat_idx",  32'(grant_index), 32'(e.idx));
          chk("beat_data", 32'(data_out),    32'(e.data));
          chk("beat_last", 32'(last_out),    32'(e.last));
        end
      end
    end
    adv = valid_in & ready_in;
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (adv[i]) begin
        if (beat[i] == len[i] - 1) begin beat[i] = 0; fcnt[i]++; fleft[i]--; end
        else beat[i]++;
      end
    end
  endtask

  task automatic tick();
    drive_sample();
    advance();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; pause_at[i] = -1; resumed[i] = 1'b0; fleft[i] = 0; beat[i] = 0;
      fcnt[i] = 0; len[i] = 1;
    end
    repeat (2) tick();
    rst_req = 1'b0;
    sb.delete();
    n_abort = 0; pend = 1'b0; chk_gap = 1'b0; rdy_pat = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) tick();
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int prev, nb;
    valid_in = '0; last_in = '0; data_in = '0; ready_out = 1'b0; reset = 1'b1;
    last_cyc = 0; last_acc_cyc = 0;

    // Reset state
    do_reset();
    drive_sample();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_ready_in", 32'(ready_in), 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_index", 32'(grant_index), 0);
    chk("rst_frame_abort", frame_abort, 0);
    advance();

    // Inputs 0 and 2 alternate 3-beat frames with 14-cycle spacing
    do_reset();
    chk_gap = 1'b1;
    src_init(0, 2, 3, 0); src_init(2, 2, 3, 0);
    push_frame(0, 0, 0, 3); push_frame(2, 0, 0, 3);
    push_frame(0, 1, 0, 3); push_frame(2, 1, 0, 3);
    drain(200);

    // All four request at once: order 0,1,2,3,0
    do_reset();
    src_init(0, 2, 2, 0); src_init(1, 1, 2, 0); src_init(2, 1, 2, 0); src_init(3, 1, 2, 0);
    push_frame(0, 0, 0, 2); push_frame(1, 0, 0, 2); push_frame(2, 0, 0, 2);
    push_frame(3, 0, 0, 2); push_frame(0, 1, 0, 2);
    drain(200);

    // Toggling backpressure mid-frame; input 3 waits for input 1's last beat
    do_reset();
    rdy_pat = 1'b1;
    src_init(1, 1, 6, 0); src_init(3, 1, 2, 0);
    push_frame(1, 0, 0, 6); push_frame(3, 0, 0, 2);
    drain(200);

    // Stall timeout: input 2 stops after two beats, input 3 is next
    do_reset();
    src_init(2, 1, 5, 0);
    pause_at[2] = 2;
    push_frame(2, 0, 0, 2);
    sb[1].last = 1'b0;
    for (int k = 0; k < 60 && n_abort == 0; k++) tick();
    chk("abort_seen", n_abort, 1);
    resumed[2] = 1'b1;
    src_init(3, 1, 2, 0);
    push_frame(3, 0, 0, 2);
    push_frame(2, 0, 2, 5);
    drain(200);
    chk("abort_cnt", n_abort, 1);

    // Reset mid-frame drops ownership and clears the round-robin pointer
    do_reset();
    src_init(1, 2, 6, 0);
    push_frame(1, 0, 0, 6); push_frame(1, 1, 0, 6);
    for (int k = 0; k < 100 && !(fcnt[1] == 1 && beat[1] == 2); k++) tick();
    chk("mid_frame_reached", 32'(fcnt[1] * 16 + beat[1]), 32'h12);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    sb.delete();
    drive_sample();
    chk("mrst_valid_out", valid_out, 0);
    chk("mrst_last_out", last_out, 0);
    chk("mrst_ready_in", 32'(ready_in), 0);
    chk("mrst_grant_valid", grant_valid, 0);
    chk("mrst_grant_index", 32'(grant_index), 0);
    chk("mrst_frame_abort", frame_abort, 0);
    advance();
    src_init(1, 1, 2, 2); src_init(3, 1, 2, 0);
    push_frame(1, 2, 0, 2); push_frame(3, 0, 0, 2);
    drain(200);

    // IFG_CYCLES=0 instance: one single-beat frame every two cycles
    prev = -1; nb = 0;
    repeat (20) begin
      drive_sample();
      if (valid_out0) begin
        nb++;
        chk("ifg0_data", 32'(data_out0), 32'hA5);
        chk("ifg0_last", 32'(last_out0), 1);
        chk("ifg0_ready", 32'(ready_in0), 32'h1);
        if (prev >= 0) chk("ifg0_period", cyc - prev, 2);
        prev = cyc;
      end
      advance();
    end
    chk("ifg0_beats", nb, 10);
    chk("ifg0_abort", 32'(frame_abort0), 0);
    chk("ifg0_index", 32'(grant_index0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
